decode_stage: RTL and testbench

//  Pipelined RV32I instruction-decode stage for the 5-stage core. Decodes the IF/ID instruction,

---
 rtl/decode_stage.sv | 247 ++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID decode, register file with WB write-through,
// immediate/control generation, load-use hazard detection and the ID/EX
// pipeline register.
module decode_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NREGS      = 32,
  localparam int REG_AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_valid_i,
  input  logic [31:0]           if_instr_i,
  input  logic [ADDR_WIDTH-1:0] if_pc_i,
  input  logic                  flush_i,
  input  logic                  wb_we_i,
  input  logic [REG_AW-1:0]     wb_rd_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic                  stall_o,
  output logic                  ex_valid_o,
  output logic [ADDR_WIDTH-1:0] ex_pc_o,
  output logic [DATA_WIDTH-1:0] ex_rd1_o,
  output logic [DATA_WIDTH-1:0] ex_rd2_o,
  output logic [DATA_WIDTH-1:0] ex_imm_o,
  output logic [REG_AW-1:0]     ex_rs1_o,
  output logic [REG_AW-1:0]     ex_rs2_o,
  output logic [REG_AW-1:0]     ex_rd_o,
  output logic [3:0]            ex_alu_ctrl_o,
  output logic [7:0]            ex_ctrl_o,
  output logic [DATA_WIDTH-1:0] a0_o
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // control bundle bit positions
  localparam int C_RW   = 0;
  localparam int C_MRD  = 1;
  localparam int C_MWR  = 2;
  localparam int C_ASRC = 3;
  localparam int C_BR   = 4;
  localparam int C_JAL  = 5;
  localparam int C_JALR = 6;
  localparam int C_ILL  = 7;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;
    logic [DATA_WIDTH-1:0] imm;
    logic [REG_AW-1:0]     rs1;
    logic [REG_AW-1:0]     rs2;
    logic [REG_AW-1:0]     rd;
    logic [3:0]            alu;
    logic [7:0]            ctrl;
  } idex_t;

  idex_t ex_q, ex_d;

  logic [NREGS-1:0][DATA_WIDTH-1:0] rf_q, rf_d;

  // instruction fields; register indices keep only the low REG_AW bits
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              funct7b5;
  logic [REG_AW-1:0] rs1_idx, rs2_idx, rd_idx;

  assign opcode   = if_instr_i[6:0];
  assign funct3   = if_instr_i[14:12];
  assign funct7b5 = if_instr_i[30];
  assign rd_idx   = if_instr_i[7  +: REG_AW];
  assign rs1_idx  = if_instr_i[15 +: REG_AW];
  assign rs2_idx  = if_instr_i[20 +: REG_AW];

  // raw 32-bit immediates for every format, sign taken from instr[31]
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

  assign imm_i = {{20{if_instr_i[31]}}, if_instr_i[31:20]};
  assign imm_s = {{20{if_instr_i[31]}}, if_instr_i[31:25], if_instr_i[11:7]};
  assign imm_b = {{19{if_instr_i[31]}}, if_instr_i[31], if_instr_i[7],
                  if_instr_i[30:25], if_instr_i[11:8], 1'b0};
  assign imm_j = {{11{if_instr_i[31]}}, if_instr_i[31], if_instr_i[19:12],
                  if_instr_i[20], if_instr_i[30:21], 1'b0};
  assign imm_u = {if_instr_i[31:12], 12'h000};

  logic [7:0]  ctrl_dec;
  logic [3:0]  alu_dec;
  logic [31:0] imm32;
  logic        uses_rs1, uses_rs2, is_lui;

  // opcode decode: control bundle, ALU op, immediate format, operand usage
  always_comb begin
    ctrl_dec = 8'h00;
    alu_dec  = ALU_ADD;
    imm32    = 32'h0;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    is_lui   = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl_dec[C_RW] = 1'b1;
        alu_dec        = {funct7b5, funct3};
        uses_rs2       = 1'b1;
      end
      OP_IALU: begin
        ctrl_dec[C_RW]   = 1'b1;
        ctrl_dec[C_ASRC] = 1'b1;
        // only the shift-right group uses instr[30] as an op qualifier;
        // elsewhere it is just an immediate bit
        alu_dec          = {(funct3 == 3'b101) ? funct7b5 : 1'b0, funct3};
        imm32            = imm_i;
      end
      OP_LOAD: begin
        ctrl_dec[C_RW]   = 1'b1;
        ctrl_dec[C_MRD]  = 1'b1;
        ctrl_dec[C_ASRC] = 1'b1;
        imm32            = imm_i;
      end
      OP_STORE: begin
        ctrl_dec[C_MWR]  = 1'b1;
        ctrl_dec[C_ASRC] = 1'b1;
        imm32            = imm_s;
        uses_rs2         = 1'b1;
      end
      OP_BRANCH: begin
        ctrl_dec[C_BR] = 1'b1;
        alu_dec        = ALU_SUB;
        imm32          = imm_b;
        uses_rs2       = 1'b1;
      end
      OP_JAL: begin
        ctrl_dec[C_RW]  = 1'b1;
        ctrl_dec[C_JAL] = 1'b1;
        imm32           = imm_j;
        uses_rs1        = 1'b0;
      end
      OP_JALR: begin
        ctrl_dec[C_RW]   = 1'b1;
        ctrl_dec[C_ASRC] = 1'b1;
        ctrl_dec[C_JALR] = 1'b1;
        imm32            = imm_i;
      end
      OP_LUI: begin
        ctrl_dec[C_RW]   = 1'b1;
        ctrl_dec[C_ASRC] = 1'b1;
        imm32            = imm_u;
        uses_rs1         = 1'b0;
        is_lui           = 1'b1;
      end
      default: begin
        ctrl_dec[C_ILL] = 1'b1;
      end
    endcase
  end

  // register reads with write-through from the WB port; x0 always reads 0
  logic [DATA_WIDTH-1:0] rs1_val, rs2_val;

  always_comb begin
    rs1_val = rf_q[rs1_idx];
    if (rs1_idx == '0)
      rs1_val = '0;
    else if (wb_we_i && (wb_rd_i == rs1_idx))
      rs1_val = wb_data_i;
  end

  // rs2 read, same bypass rule as rs1
  always_comb begin
    rs2_val = rf_q[rs2_idx];
    if (rs2_idx == '0)
      rs2_val = '0;
    else if (wb_we_i && (wb_rd_i == rs2_idx))
      rs2_val = wb_data_i;
  end

  // load-use hazard against the instruction currently in ID/EX
  logic hazard;

  assign hazard = if_valid_i && ex_q.valid && ex_q.ctrl[C_MRD] && (ex_q.rd != '0) &&
                  ((uses_rs1 && (rs1_idx == ex_q.rd)) ||
                   (uses_rs2 && (rs2_idx == ex_q.rd)));

  // a redirect kills the dependent instruction, so there is nothing to hold
  assign stall_o = hazard && !flush_i;

  // ID/EX next state: decoded bundle, downgraded to a bubble on
  // flush, hazard or an empty IF/ID slot (payload fields left as-is)
  always_comb begin
    ex_d       = '0;
    ex_d.valid = 1'b1;
    ex_d.pc    = if_pc_i;
    ex_d.rd1   = is_lui ? '0 : rs1_val;
    ex_d.rd2   = rs2_val;
    ex_d.imm   = DATA_WIDTH'($signed(imm32));
    ex_d.rs1   = rs1_idx;
    ex_d.rs2   = rs2_idx;
    ex_d.rd    = rd_idx;
    ex_d.alu   = alu_dec;
    ex_d.ctrl  = ctrl_dec;
    if (flush_i || hazard || !if_valid_i) begin
      ex_d.valid = 1'b0;
      ex_d.ctrl  = 8'h00;
    end
  end

  // register file next state; x0 is never written so it stays 0 after reset
  always_comb begin
    rf_d = rf_q;
    if (wb_we_i && (wb_rd_i != '0))
      rf_d[wb_rd_i] = wb_data_i;
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  // register file storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rf_q <= '0;
    else        rf_q <= rf_d;
  end

  assign ex_valid_o    = ex_q.valid;
  assign ex_pc_o       = ex_q.pc;
  assign ex_rd1_o      = ex_q.rd1;
  assign ex_rd2_o      = ex_q.rd2;
  assign ex_imm_o      = ex_q.imm;
  assign ex_rs1_o      = ex_q.rs1;
  assign ex_rs2_o      = ex_q.rs2;
  assign ex_rd_o       = ex_q.rd;
  assign ex_alu_ctrl_o = ex_q.alu;
  assign ex_ctrl_o     = ex_q.ctrl;
  assign a0_o          = rf_q[10];

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: an instruction-level model predicts ID/EX contents,
// stall and x10 every cycle; directed vectors add literal expectations.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_instr = '0;
  logic [31:0] if_pc = '0;
  logic        flush = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        stall_o, ex_valid_o;
  logic [31:0] ex_pc_o, ex_rd1_o, ex_rd2_o, ex_imm_o, a0_o;
  logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [3:0]  ex_alu_ctrl_o;
  logic [7:0]  ex_ctrl_o;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid_i(if_valid), .if_instr_i(if_instr), .if_pc_i(if_pc), .flush_i(flush),
    .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .stall_o(stall_o), .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
    .ex_rd1_o(ex_rd1_o), .ex_rd2_o(ex_rd2_o), .ex_imm_o(ex_imm_o),
    .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o),
    .ex_alu_ctrl_o(ex_alu_ctrl_o), .ex_ctrl_o(ex_ctrl_o), .a0_o(a0_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    logic        v;
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu;
    logic [7:0]  ctrl;
  } ex_t;

  ex_t         m;
  logic [31:0] mrf [32];

  task automatic model_reset();
    m = '{v: 1'b0, pc: '0, rd1: '0, rd2: '0, imm: '0, rs1: '0, rs2: '0, rd: '0, alu: '0, ctrl: '0};
    for (int i = 0; i < 32; i++) mrf[i] = '0;
  endtask

  function automatic logic [31:0] mread(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (wb_we && wb_rd == idx) return wb_data;
    return mrf[idx];
  endfunction

  // what the instruction means: control word, ALU op, immediate, operand use
  function automatic void mdecode(input logic [31:0] ins, output logic [7:0] c,
                                  output logic [3:0] a, output logic [31:0] im,
                                  output bit u1, output bit u2);
    logic signed [31:0] s, sx20, sx25, sx31;
    logic [2:0] f3;
    s = ins; sx20 = s >>> 20; sx25 = s >>> 25; sx31 = s >>> 31;
    f3 = ins[14:12];
    u1 = 1; u2 = 0; a = 4'h0; im = 32'h0; c = 8'h80;
    case (ins[6:0])
      7'h33: begin c = 8'h01; a = {ins[30], f3}; u2 = 1; end
      7'h13: begin c = 8'h09; a = (f3 == 3'd5) ? {ins[30], f3} : {1'b0, f3}; im = sx20; end
      7'h03: begin c = 8'h0B; im = sx20; end
      7'h23: begin c = 8'h0C; im = (sx25 << 5) | 32'(ins[11:7]); u2 = 1; end
      7'h63: begin
        c = 8'h10; a = 4'b1000; u2 = 1;
        im = (sx31 << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      end
      7'h6F: begin
        c = 8'h21; u1 = 0;
        im = (sx31 << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      end
      7'h67: begin c = 8'h49; im = sx20; end
      7'h37: begin c = 8'h09; im = ins & 32'hFFFF_F000; u1 = 0; end
      default: c = 8'h80;
    endcase
  endfunction

  // one cycle: compare DUT against model at negedge, then advance the model
  task automatic tick();
    ex_t nx;
    logic [7:0]  c;
    logic [3:0]  a;
    logic [31:0] im;
    bit u1, u2, haz;
    @(negedge clk);
    chk("ex_valid", ex_valid_o, m.v);
    chk("ex_ctrl", ex_ctrl_o, m.ctrl);
    chk("a0", a0_o, mrf[10]);
    if (m.v) begin
      chk("ex_pc", ex_pc_o, m.pc);
      chk("ex_rd1", ex_rd1_o, m.rd1);
      chk("ex_rd2", ex_rd2_o, m.rd2);
      chk("ex_imm", ex_imm_o, m.imm);
      chk("ex_rs1", ex_rs1_o, m.rs1);
      chk("ex_rs2", ex_rs2_o, m.rs2);
      chk("ex_rd", ex_rd_o, m.rd);
      chk("ex_alu", ex_alu_ctrl_o, m.alu);
    end
    mdecode(if_instr, c, a, im, u1, u2);
    haz = if_valid && m.v && m.ctrl[1] && (m.rd != 0) &&
          ((u1 && if_instr[19:15] == m.rd) || (u2 && if_instr[24:20] == m.rd));
    chk("stall", stall_o, haz && !flush);
    nx.v    = if_valid && !flush && !haz;
    nx.ctrl = nx.v ? c : 8'h00;
    nx.pc   = if_pc;
    nx.rd1  = (if_instr[6:0] == 7'h37) ? 32'h0 : mread(if_instr[19:15]);
    nx.rd2  = mread(if_instr[24:20]);
    nx.imm  = im;
    nx.rs1  = if_instr[19:15];
    nx.rs2  = if_instr[24:20];
    nx.rd   = if_instr[11:7];
    nx.alu  = a;
    @(posedge clk);
    m = nx;
    if (wb_we && wb_rd != 0) mrf[wb_rd] = wb_data;
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic we, input logic [4:0] rd, input logic [31:0] d);
    if_valid = v; if_instr = ins; if_pc = pc; flush = fl;
    wb_we = we; wb_rd = rd; wb_data = d;
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  // ---------------- directed vectors ----------------
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", ex_valid_o, 1'b0);
    chk("rst_ctrl", ex_ctrl_o, 8'h00);
    chk("rst_a0", a0_o, 32'h0);
    rst_n = 1'b1;

    // bypass: x5 written in the same cycle ADD x1,x5,x0 reads it
    drive(1, enc_r(7'h00, 5'd0, 5'd5, 3'd0, 5'd1), 32'h100, 0, 1, 5'd5, 32'hDEAD_BEEF);
    tick();
    chk("byp_rd1", ex_rd1_o, 32'hDEAD_BEEF);
    chk("byp_ctrl", ex_ctrl_o, 8'h01);

    // x10 write shows on a0
    drive(0, 32'h0, 32'h104, 0, 1, 5'd10, 32'h0000_1234);
    tick();
    chk("a0_wr", a0_o, 32'h0000_1234);
    chk("idle_valid", ex_valid_o, 1'b0);

    // x0 stays zero, even when WB targets x0 in the reading cycle
    drive(0, 32'h0, 32'h108, 0, 1, 5'd0, 32'd5);
    tick();
    drive(1, enc_i(12'hFFF, 5'd0, 3'd0, 5'd2, 7'h13), 32'h10C, 0, 1, 5'd0, 32'd7);
    tick();
    chk("x0_rd1", ex_rd1_o, 32'h0);
    chk("x0_imm", ex_imm_o, 32'hFFFF_FFFF);
    chk("x0_alu", ex_alu_ctrl_o, 4'b0000);
    chk("x0_ctrl", ex_ctrl_o, 8'h09);

    // load-use with a WB write to the same register during the stall
    drive(1, enc_i(12'h000, 5'd1, 3'd2, 5'd3, 7'h03), 32'h110, 0, 0, 5'd0, 32'h0);
    tick();
    chk("lw_ctrl", ex_ctrl_o, 8'h0B);
    drive(1, enc_r(7'h00, 5'd3, 5'd3, 3'd0, 5'd4), 32'h114, 0, 1, 5'd3, 32'h55);
    #1 chk("lu_stall", stall_o, 1'b1);
    tick();
    chk("lu_bubble", ex_valid_o, 1'b0);
    drive(1, enc_r(7'h00, 5'd3, 5'd3, 3'd0, 5'd4), 32'h114, 0, 0, 5'd0, 32'h0);
    #1 chk("lu_release", stall_o, 1'b0);
    tick();
    chk("lu_issue", ex_valid_o, 1'b1);
    chk("lu_rd1", ex_rd1_o, 32'h55);
    chk("lu_rd2", ex_rd2_o, 32'h55);

    // flush and hazard in the same cycle
    drive(1, enc_i(12'h004, 5'd2, 3'd2, 5'd6, 7'h03), 32'h118, 0, 0, 5'd0, 32'h0);
    tick();
    drive(1, enc_r(7'h00, 5'd1, 5'd6, 3'd0, 5'd7), 32'h11C, 1, 0, 5'd0, 32'h0);
    #1 chk("fl_stall", stall_o, 1'b0);
    tick();
    chk("fl_valid", ex_valid_o, 1'b0);
    drive(1, enc_i(12'h001, 5'd6, 3'd0, 5'd8, 7'h13), 32'h200, 0, 0, 5'd0, 32'h0);
    #1 chk("fl_next_stall", stall_o, 1'b0);
    tick();
    chk("fl_next_pc", ex_pc_o, 32'h200);

    // I-type: imm field equal to the load rd is not an rs2 use
    drive(1, enc_i(12'h000, 5'd1, 3'd2, 5'd3, 7'h03), 32'h204, 0, 0, 5'd0, 32'h0);
    tick();
    drive(1, enc_i(12'h003, 5'd1, 3'd0, 5'd5, 7'h13), 32'h208, 0, 0, 5'd0, 32'h0);
    #1 chk("immrs2_stall", stall_o, 1'b0);
    tick();
    // store uses rs2
    drive(1, enc_i(12'h000, 5'd1, 3'd2, 5'd3, 7'h03), 32'h20C, 0, 0, 5'd0, 32'h0);
    tick();
    drive(1, enc_s(12'h008, 5'd3, 5'd0), 32'h210, 0, 0, 5'd0, 32'h0);
    #1 chk("sw_stall", stall_o, 1'b1);
    tick();
    tick();
    chk("sw_imm", ex_imm_o, 32'h8);
    chk("sw_ctrl", ex_ctrl_o, 8'h0C);
    // empty slot and load to x0 never stall
    drive(1, enc_i(12'h000, 5'd1, 3'd2, 5'd3, 7'h03), 32'h214, 0, 0, 5'd0, 32'h0);
    tick();
    drive(0, enc_r(7'h00, 5'd3, 5'd3, 3'd0, 5'd4), 32'h218, 0, 0, 5'd0, 32'h0);
    #1 chk("novalid_stall", stall_o, 1'b0);
    tick();
    drive(1, enc_i(12'h000, 5'd1, 3'd2, 5'd0, 7'h03), 32'h21C, 0, 0, 5'd0, 32'h0);
    tick();
    drive(1, enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd4), 32'h220, 0, 0, 5'd0, 32'h0);
    #1 chk("x0load_stall", stall_o, 1'b0);
    tick();

    // immediates and control words
    drive(1, enc_b(13'h1FF8, 5'd2, 5'd1), 32'h300, 0, 0, 5'd0, 32'h0);
    tick();
    chk("beq_imm", ex_imm_o, 32'hFFFF_FFF8);
    chk("beq_ctrl", ex_ctrl_o, 8'h10);
    chk("beq_alu", ex_alu_ctrl_o, 4'b1000);
    drive(1, 32'h0000_007F, 32'h304, 0, 0, 5'd0, 32'h0);
    tick();
    chk("ill_ctrl", ex_ctrl_o, 8'h80);
    chk("ill_valid", ex_valid_o, 1'b1);
    drive(1, enc_r(7'h20, 5'd3, 5'd2, 3'd0, 5'd1), 32'h308, 0, 0, 5'd0, 32'h0);
    tick();
    chk("sub_alu", ex_alu_ctrl_o, 4'b1000);
    drive(1, enc_i({7'h20, 5'd3}, 5'd6, 3'd5, 5'd5, 7'h13), 32'h30C, 0, 0, 5'd0, 32'h0);
    tick();
    chk("srai_alu", ex_alu_ctrl_o, 4'b1101);
    drive(1, enc_i(12'h400, 5'd6, 3'd0, 5'd5, 7'h13), 32'h310, 0, 0, 5'd0, 32'h0);
    tick();
    chk("addi_b30_alu", ex_alu_ctrl_o, 4'b0000);
    drive(1, enc_j(21'h1FFFFC, 5'd1), 32'h314, 0, 0, 5'd0, 32'h0);
    tick();
    chk("jal_imm", ex_imm_o, 32'hFFFF_FFFC);
    chk("jal_ctrl", ex_ctrl_o, 8'h21);
    drive(1, enc_i(12'h010, 5'd2, 3'd0, 5'd1, 7'h67), 32'h318, 0, 0, 5'd0, 32'h0);
    tick();
    chk("jalr_ctrl", ex_ctrl_o, 8'h49);
    // LUI's rs1 field decodes to x8, written through this cycle; rd1 must still be 0
    drive(1, {20'h12345, 5'd9, 7'h37}, 32'h31C, 0, 1, 5'd8, 32'h99);
    tick();
    chk("lui_imm", ex_imm_o, 32'h1234_5000);
    chk("lui_rd1", ex_rd1_o, 32'h0);

    // reset in mid-stream clears pipeline and register file
    drive(1, enc_r(7'h00, 5'd5, 5'd10, 3'd0, 5'd1), 32'h400, 0, 0, 5'd0, 32'h0);
    tick();
    rst_n = 1'b0;
    #2;
    chk("mrst_valid", ex_valid_o, 1'b0);
    chk("mrst_ctrl", ex_ctrl_o, 8'h00);
    chk("mrst_a0", a0_o, 32'h0);
    model_reset();
    rst_n = 1'b1;
    drive(1, enc_r(7'h00, 5'd5, 5'd10, 3'd0, 5'd1), 32'h404, 0, 0, 5'd0, 32'h0);
    tick();
    chk("mrst_rd1", ex_rd1_o, 32'h0);
    chk("mrst_rd2", ex_rd2_o, 32'h0);
    drive(0, 32'h0, 32'h0, 0, 0, 5'd0, 32'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
